uart_wishbone_host: RTL and testbench

Host-side initiator for the UART Wishbone link: a Wishbone slave that turns each local bus cycle into a 4-byte UART command frame. It then waits for the 1-byte response returned by the remote UART-to-Wishbone bridge and completes the local cycle with `ack_o`. It sits in test/host FPGA designs that drive the chip's UART debug port.

---
 rtl/uart_wishbone_host_if.sv | 22 ++
 rtl/uart_wishbone_host.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_wishbone_host.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_wishbone_host_if.sv
// Wishbone classic bus bundle between a local master and the UART link host.
// The slave modport is the host's view; the master modport is the initiator's view.
interface uart_wishbone_host_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [22:0] adr_i;
  logic [7:0]  dat_i;
  logic [7:0]  dat_o;
  logic        ack_o;
  logic        err_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o, err_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o, err_o
  );
endinterface

// File: rtl/uart_wishbone_host.sv
// Wishbone slave that serialises each bus cycle into a 4-byte 8N1 UART frame and completes it on the 1-byte reply.
// Optional response timeout with err_o pulse: define UART_WB_HOST_TIMEOUT_EN.
module uart_wishbone_host #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  uart_wishbone_host_if.slave  wb,
  output logic                 uart_txd,
  input  logic                 uart_rxd
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  if (CLKS_PER_BIT < 4 || TIMEOUT_CLKS < 1) begin : g_bad_params
    $error("uart_wishbone_host: CLKS_PER_BIT must be >= 4 and TIMEOUT_CLKS >= 1");
  end

  typedef enum logic [3:0] {
    IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    RX_WAIT,
    RX_START,
    RX_DATA,
    RX_STOP,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]     tx_buf_q, tx_buf_d;
  logic [7:0]      rx_buf_q, rx_buf_d;
  logic [7:0]      dat_q, dat_d;
  logic            ack_q, ack_d;
  logic            txd_q, txd_d;
  logic            rxd_meta_q, rxd_meta_d;
  logic            rxd_sync_q, rxd_sync_d;
  logic [7:0]      tx_byte;
  logic            bit_done;
  logic            req;

`ifdef UART_WB_HOST_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CLKS - 1);
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
`endif

  assign bit_done = (clk_cnt_q == BIT_LAST);
  assign req      = wb.cyc_i & wb.stb_i;

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    tx_buf_d   = tx_buf_q;
    rx_buf_d   = rx_buf_q;
    dat_d      = dat_q;
    ack_d      = 1'b0;
    rxd_meta_d = uart_rxd;
    rxd_sync_d = rxd_meta_q;
    tx_byte    = 8'h00;
    txd_d      = 1'b1;
`ifdef UART_WB_HOST_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    err_d      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (req) begin
          // Reads carry a zero data byte so the remote always sees 4 bytes.
          tx_buf_d   = {wb.we_i, wb.adr_i, (wb.we_i ? wb.dat_i : 8'h00)};
          clk_cnt_d  = '0;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          state_d    = TX_START;
        end
      end
      TX_START: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = TX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = TX_STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (bit_done) begin
          clk_cnt_d  = '0;
          byte_cnt_d = byte_cnt_q + 1'b1;
          tx_buf_d   = {tx_buf_q[23:0], 8'h00};
          if (byte_cnt_q == 2'd3) begin
            state_d = RX_WAIT;
`ifdef UART_WB_HOST_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end else begin
            state_d = TX_START;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_WAIT: begin
        if (!rxd_sync_q) begin
          clk_cnt_d = '0;
          state_d   = RX_START;
        end
      end
      RX_START: begin
        // Re-check the start bit mid-bit so short line glitches are rejected.
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rxd_sync_q ? RX_WAIT : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          rx_buf_d  = {rxd_sync_q, rx_buf_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          if (rxd_sync_q) begin
            // An abandoned cycle still consumes its reply, just without ack.
            state_d = RESP;
            if (req) begin
              ack_d = 1'b1;
              dat_d = rx_buf_q;
            end
          end else begin
            state_d = RX_WAIT;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef UART_WB_HOST_TIMEOUT_EN
    if ((state_q inside {RX_WAIT, RX_START, RX_DATA, RX_STOP}) && (state_d != RESP)) begin
      if (to_cnt_q == TIMEOUT_LAST) begin
        state_d   = IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        err_d     = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif

    // txd is registered from next-state values so it changes on the accept edge.
    tx_byte = tx_buf_d[31:24];
    case (state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_byte[bit_cnt_d];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      tx_buf_q   <= '0;
      rx_buf_q   <= '0;
      dat_q      <= 8'h00;
      ack_q      <= 1'b0;
      txd_q      <= 1'b1;
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      tx_buf_q   <= tx_buf_d;
      rx_buf_q   <= rx_buf_d;
      dat_q      <= dat_d;
      ack_q      <= ack_d;
      txd_q      <= txd_d;
      rxd_meta_q <= rxd_meta_d;
      rxd_sync_q <= rxd_sync_d;
    end
  end

`ifdef UART_WB_HOST_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign wb.err_o = err_q;
`else
  assign wb.err_o = 1'b0;
`endif

  assign wb.ack_o  = ack_q;
  assign wb.dat_o  = dat_q;
  assign uart_txd  = txd_q;

endmodule

// File: tb/tb_uart_wishbone_host.sv
// Randomised bench for uart_wishbone_host: a UART line model on both pins and a frame/response reference model.
module tb_uart_wishbone_host;
  localparam int C  = 16;
  localparam int TO = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;
  logic txd;

  uart_wishbone_host_if w();

  uart_wishbone_host #(.CLKS_PER_BIT(C), .TIMEOUT_CLKS(TO)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .wb      (w),
    .uart_txd(txd),
    .uart_rxd(rxd)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int          vectors = 0;
  int          miscompares = 0;
  int          ack_seen = 0;
  int          err_seen = 0;
  int          ack_cyc = 0;
  int          err_cyc = 0;
  logic [7:0]  ack_dat = 8'h00;
  logic [7:0]  last_dat = 8'h00;
  bit          drop_on_ack = 1'b1;
  bit          b2b_arm = 1'b0;
  logic        nxt_we;
  logic [22:0] nxt_adr;
  logic [7:0]  nxt_dat;

  initial begin
    w.cyc_i = 1'b0;
    w.stb_i = 1'b0;
    w.we_i  = 1'b0;
    w.adr_i = '0;
    w.dat_i = '0;
  end

  // Reference: the frame is the request packed MSB-first as one 32-bit word.
  function automatic logic [31:0] frame_of(input logic we, input logic [22:0] adr, input logic [7:0] dat);
    return (32'(we) << 31) + (32'(adr) << 8) + (we ? 32'(dat) : 32'd0);
  endfunction

  // Every wait goes through here so acks/errors are never missed.
  task automatic tick();
    @(negedge clk);
    if (w.ack_o === 1'b1) begin
      ack_seen++;
      ack_dat = w.dat_o;
      ack_cyc = cyc_n;
      if (b2b_arm) begin
        w.we_i  = nxt_we;
        w.adr_i = nxt_adr;
        w.dat_i = nxt_dat;
        b2b_arm = 1'b0;
      end else if (drop_on_ack) begin
        w.cyc_i = 1'b0;
        w.stb_i = 1'b0;
      end
    end
    if (w.err_o === 1'b1) begin
      err_seen++;
      err_cyc = cyc_n;
      w.cyc_i = 1'b0;
      w.stb_i = 1'b0;
    end
  endtask

  task automatic start_req(input logic we, input logic [22:0] adr, input logic [7:0] dat);
    tick();
    w.we_i  = we;
    w.adr_i = adr;
    w.dat_i = dat;
    w.cyc_i = 1'b1;
    w.stb_i = 1'b1;
    tick();
    vectors++;
    if (txd !== 1'b0) begin
      miscompares++;
      $display("FAIL accept_to_start: txd=%b one clock after accept, expected 0", txd);
    end
    // Inputs are latched at accept; scramble them to prove it.
    w.we_i  = 1'($urandom);
    w.adr_i = 23'($urandom);
    w.dat_i = 8'($urandom);
  endtask

  task automatic capture_byte(output logic [7:0] b, output int st, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    b  = 8'h00;
    while (txd !== 1'b0 && n < 20 * C) begin
      tick();
      n++;
    end
    st = cyc_n;
    if (txd !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (C / 2) tick();
    if (txd !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (C) tick();
      b[i] = txd;
    end
    repeat (C) tick();
    if (txd !== 1'b1) ok = 1'b0;
  endtask

  task automatic check_frame(input logic we, input logic [22:0] adr, input logic [7:0] dat,
                             input int abort_after, output int t0);
    logic [31:0] frame;
    logic [7:0]  b;
    logic [7:0]  exp_b;
    int          st;
    bit          ok;
    frame = frame_of(we, adr, dat);
    t0 = 0;
    for (int k = 0; k < 4; k++) begin
      capture_byte(b, st, ok);
      exp_b = 8'((frame >> (8 * (3 - k))) & 32'hFF);
      vectors++;
      if (!ok || b !== exp_b) begin
        miscompares++;
        $display("FAIL frame_byte%0d: got %h (framing_ok=%0d), expected %h", k, b, ok, exp_b);
      end
      if (k == 0) begin
        t0 = st;
      end else begin
        vectors++;
        if (st - t0 != 10 * C * k) begin
          miscompares++;
          $display("FAIL byte%0d_offset: start at +%0d clocks, expected +%0d", k, st - t0, 10 * C * k);
        end
      end
      if (k == abort_after) begin
        w.cyc_i = 1'b0;
        w.stb_i = 1'b0;
      end
    end
    repeat (C / 2 + 2) tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input bit stop, input bit exit_on_ack, output int stop_cyc);
    tick();
    rxd = 1'b0;
    repeat (C - 1) tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      rxd = d[i];
      repeat (C - 1) tick();
    end
    tick();
    rxd = stop;
    stop_cyc = cyc_n;
    for (int j = 0; j < C - 1; j++) begin
      if (exit_on_ack && ack_seen > 0) break;
      tick();
    end
    if (!(exit_on_ack && ack_seen > 0)) tick();
    rxd = 1'b1;
  endtask

  task automatic check_ack(input string name, input int exp_n, input logic [7:0] exp_d, input int stop_cyc);
    vectors++;
    if (ack_seen != exp_n) begin
      miscompares++;
      $display("FAIL %s_ack_count: got %0d ack cycles, expected %0d", name, ack_seen, exp_n);
    end
    if (exp_n > 0) begin
      vectors++;
      if (ack_dat !== exp_d) begin
        miscompares++;
        $display("FAIL %s_ack_data: got %h, expected %h", name, ack_dat, exp_d);
      end
      vectors++;
      if (ack_cyc - stop_cyc < 1 || ack_cyc - stop_cyc > C) begin
        miscompares++;
        $display("FAIL %s_ack_time: ack %0d clocks into stop bit, expected 1..%0d", name, ack_cyc - stop_cyc, C);
      end
    end
    vectors++;
    if (w.dat_o !== exp_d) begin
      miscompares++;
      $display("FAIL %s_dat_hold: dat_o=%h, expected %h", name, w.dat_o, exp_d);
    end
  endtask

  task automatic do_txn(input string name, input logic we, input logic [22:0] adr,
                        input logic [7:0] dat, input logic [7:0] resp);
    int t0;
    int sc;
    ack_seen = 0;
    start_req(we, adr, dat);
    check_frame(we, adr, dat, -1, t0);
    send_byte(resp, 1'b1, 1'b0, sc);
    repeat (C) tick();
    last_dat = resp;
    check_ack(name, 1, resp, sc);
    $display("txn %s we=%0d adr=%h dat=%h resp=%h acks=%0d", name, we, adr, dat, resp, ack_seen);
  endtask

  task automatic test_reset();
    int lows;
    rst_n = 1'b0;
    repeat (4) tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (txd !== 1'b1) begin miscompares++; $display("FAIL reset_txd: got %b, expected 1", txd); end
    vectors++;
    if (w.ack_o !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b, expected 0", w.ack_o); end
    vectors++;
    if (w.err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b, expected 0", w.err_o); end
    vectors++;
    if (w.dat_o !== 8'h00) begin miscompares++; $display("FAIL reset_dat: got %h, expected 00", w.dat_o); end
    lows = 0;
    repeat (1000) begin
      tick();
      if (txd !== 1'b1) lows++;
    end
    vectors++;
    if (lows != 0) begin miscompares++; $display("FAIL idle_quiet: txd not high on %0d clocks, expected 0", lows); end
    last_dat = 8'h00;
    $display("txn reset idle_low_clocks=%0d", lows);
  endtask

  task automatic test_write();
    do_txn("write", 1'b1, 23'h123456, 8'hA5, 8'h00);
  endtask

  task automatic test_read();
    do_txn("read", 1'b0, 23'h000100, 8'h00, 8'h3C);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      do_txn("random", 1'($urandom), 23'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_faults();
    int t0;
    int sc;
    logic [22:0] adr;
    adr = 23'($urandom);
    ack_seen = 0;
    start_req(1'b0, adr, 8'h00);
    check_frame(1'b0, adr, 8'h00, -1, t0);
    tick();
    rxd = 1'b0;
    repeat (4) tick();
    rxd = 1'b1;
    repeat (3 * C) tick();
    vectors++;
    if (ack_seen != 0) begin miscompares++; $display("FAIL glitch_no_ack: got %0d acks, expected 0", ack_seen); end
    send_byte(8'h5A, 1'b0, 1'b0, sc);
    repeat (2 * C) tick();
    check_ack("bad_stop", 0, last_dat, sc);
    send_byte(8'h7E, 1'b1, 1'b0, sc);
    repeat (C) tick();
    last_dat = 8'h7E;
    check_ack("after_fault", 1, 8'h7E, sc);
    $display("txn faults adr=%h final_acks=%0d dat=%h", adr, ack_seen, ack_dat);
  endtask

  task automatic test_abort();
    int t0;
    int sc;
    logic [22:0] adr;
    logic [7:0]  dat;
    adr = 23'($urandom);
    dat = 8'($urandom);
    ack_seen = 0;
    start_req(1'b1, adr, dat);
    check_frame(1'b1, adr, dat, 1, t0);
    send_byte(8'h11, 1'b1, 1'b0, sc);
    repeat (2 * C) tick();
    check_ack("abort", 0, last_dat, sc);
    $display("txn abort adr=%h acks=%0d", adr, ack_seen);
    do_txn("after_abort", 1'b0, 23'($urandom), 8'h00, 8'($urandom));
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    int sc;
    int a1;
    logic [22:0] adr1;
    logic [7:0]  r1;
    logic [7:0]  r2;
    adr1    = 23'($urandom);
    r1      = 8'($urandom);
    r2      = 8'($urandom);
    nxt_we  = 1'b1;
    nxt_adr = 23'($urandom);
    nxt_dat = 8'($urandom);
    ack_seen = 0;
    start_req(1'b0, adr1, 8'h00);
    check_frame(1'b0, adr1, 8'h00, -1, t0);
    drop_on_ack = 1'b0;
    b2b_arm     = 1'b1;
    send_byte(r1, 1'b1, 1'b1, sc);
    drop_on_ack = 1'b1;
    b2b_arm     = 1'b0;
    last_dat    = r1;
    check_ack("b2b_first", 1, r1, sc);
    a1 = ack_cyc;
    ack_seen = 0;
    check_frame(nxt_we, nxt_adr, nxt_dat, -1, t1);
    vectors++;
    if (t1 - a1 != 2) begin
      miscompares++;
      $display("FAIL b2b_reaccept: second frame started %0d clocks after ack, expected 2", t1 - a1);
    end
    send_byte(r2, 1'b1, 1'b0, sc);
    repeat (C) tick();
    last_dat = r2;
    check_ack("b2b_second", 1, r2, sc);
    $display("txn back_to_back gap=%0d resp1=%h resp2=%h", t1 - a1, r1, r2);
  endtask

  task automatic test_timeout();
    int t0;
    int sc;
    logic [22:0] adr;
    adr = 23'($urandom);
    ack_seen = 0;
    err_seen = 0;
    start_req(1'b0, adr, 8'h00);
    check_frame(1'b0, adr, 8'h00, -1, t0);
`ifdef UART_WB_HOST_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (err_seen == 0 && n < TO + 200) begin
        tick();
        n++;
      end
      repeat (4) tick();
      vectors++;
      if (err_seen != 1) begin miscompares++; $display("FAIL timeout_err_count: got %0d err cycles, expected 1", err_seen); end
      vectors++;
      if (err_cyc - t0 != 40 * C + TO) begin
        miscompares++;
        $display("FAIL timeout_err_time: err at +%0d clocks, expected +%0d", err_cyc - t0, 40 * C + TO);
      end
      send_byte(8'h55, 1'b1, 1'b0, sc);
      repeat (2 * C) tick();
      check_ack("timeout", 0, last_dat, sc);
    end
`else
    begin
      int lows;
      lows = 0;
      repeat (TO + 500) begin
        tick();
        if (txd !== 1'b1) lows++;
      end
      vectors++;
      if (err_seen != 0) begin miscompares++; $display("FAIL no_timeout_err: got %0d err cycles, expected 0", err_seen); end
      vectors++;
      if (lows != 0) begin miscompares++; $display("FAIL wait_quiet: txd low on %0d clocks, expected 0", lows); end
      w.cyc_i = 1'b0;
      w.stb_i = 1'b0;
      send_byte(8'h55, 1'b1, 1'b0, sc);
      repeat (2 * C) tick();
      check_ack("late_resp", 0, last_dat, sc);
    end
`endif
    $display("txn timeout adr=%h errs=%0d acks=%0d", adr, err_seen, ack_seen);
    do_txn("after_timeout", 1'b1, 23'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic test_reset_mid();
    int lows;
    ack_seen = 0;
    start_req(1'b1, 23'($urandom), 8'($urandom));
    repeat (5) tick();
    rst_n   = 1'b0;
    w.cyc_i = 1'b0;
    w.stb_i = 1'b0;
    tick();
    vectors++;
    if (txd !== 1'b1) begin miscompares++; $display("FAIL reset_mid_txd: got %b, expected 1", txd); end
    repeat (3) tick();
    rst_n = 1'b1;
    last_dat = 8'h00;
    lows = 0;
    repeat (800) begin
      tick();
      if (txd !== 1'b1) lows++;
    end
    vectors++;
    if (lows != 0) begin miscompares++; $display("FAIL reset_mid_quiet: txd low on %0d clocks, expected 0", lows); end
    vectors++;
    if (ack_seen != 0 || w.dat_o !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid_ack: got %0d acks dat_o=%h, expected 0 acks dat_o=00", ack_seen, w.dat_o);
    end
    $display("txn reset_mid acks=%0d", ack_seen);
    do_txn("after_reset", 1'b0, 23'($urandom), 8'h00, 8'($urandom));
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_random();
    test_faults();
    test_abort();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
